change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have the parameter PRICE, default 6, meaning the product price in 5-cent units (6 = 30 cents).
REQ-002 The block SHALL have the parameter TIMEOUT, default 16, meaning the maximum number of cycles to wait for hopper_ack, in the range 2..255.
REQ-003 The block SHALL have the port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port start  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have the port credit_valid  input  1  pulse presenting a settled credit.
REQ-006 The block SHALL have the port credit  input  4  credit in 5-cent units (0..15 = 0..75 cents).
REQ-007 The block SHALL have the port hopper_ack  input  1  the coin hopper accepted the currently requested coin.
REQ-008 The block SHALL have the port vend  output  1  one-cycle pulse that releases the product.
REQ-009 The block SHALL have the port coin10  output  1  request to eject one 10-cent coin.
REQ-010 The block SHALL have the port coin5  output  1  request to eject one 5-cent coin.
REQ-011 The block SHALL have the port refund  output  1  the current transaction is a full refund (credit below PRICE).
REQ-012 The block SHALL have the port busy  output  1  a transaction is in progress.
REQ-013 The block SHALL have the port done  output  1  one-cycle pulse marking the end of a transaction.
REQ-014 The block SHALL have the port jam  output  1  sticky hopper-timeout flag.

Function
REQ-015 The block SHALL implement the states IDLE, VEND, PAY, GAP, DONE and JAM; all outputs SHALL be registered.
REQ-016 In IDLE with credit_valid=1, the block SHALL latch credit. If credit>=PRICE, it SHALL move to VEND with remaining=credit-PRICE and refund=0. Otherwise it SHALL move to PAY with remaining=credit and refund=1.
REQ-017 The block SHALL ignore credit_valid in every state other than IDLE; no queuing.
REQ-018 With credit=0, the block SHALL go from IDLE directly to DONE, with refund=0 and no coins ejected.
REQ-019 The block SHALL assert vend for exactly one cycle, during VEND, which is the cycle after acceptance. Next state: PAY if remaining>0, else DONE.
REQ-020 In PAY, the block SHALL assert coin10 if remaining>=2, else coin5; coin10 and coin5 are never high together.
REQ-021 The coin request SHALL stay high until hopper_ack=1 is sampled in PAY. On that edge, the block SHALL decrement remaining by 2 (coin10) or 1 (coin5) and move to GAP.
REQ-022 In GAP, the block SHALL hold coin10 and coin5 low for exactly one cycle. Next state: PAY if remaining>0, else DONE.
REQ-023 The block SHALL ignore hopper_ack outside PAY.
REQ-024 The block SHALL keep a wait counter that clears on entry to PAY and increments each PAY cycle without ack. When it reaches TIMEOUT, the block SHALL move to JAM.
REQ-025 In JAM, the block SHALL hold jam=1, busy=1 and coin10/coin5/vend low until start.
REQ-026 In DONE, the block SHALL assert done for one cycle, clear refund and return to IDLE; credit_valid in that cycle SHALL be ignored.
REQ-027 The block SHALL drive busy=1 in VEND, PAY, GAP and JAM, and busy=0 in IDLE and DONE.
REQ-028 The block SHALL hold refund for the whole transaction, from the PAY entry through the last GAP.
REQ-029 The block SHALL use a 4-bit remaining register that never underflows, because the greedy rule never requests more than remains.
REQ-030 The total ejected value SHALL equal credit-PRICE when credit>=PRICE, and credit otherwise.

Reset
REQ-031 With start=1 on a rising edge, the block SHALL, from the next cycle, be in IDLE with remaining=0 and wait counter=0, and with vend, coin10, coin5, refund, busy, done and jam all 0.
REQ-032 Reset SHALL take priority over every state and input, including a reset arriving mid-PAY with coin10 high and the exit from JAM.
REQ-033 The block SHALL produce no vend, coin or done pulse in the cycle after reset is released unless credit_valid arrives in IDLE.

Verification
REQ-034 Verification SHALL cover: credit=7, ack 1 cycle after each request -> vend at T+1, one coin5, done, total 5 cents.
REQ-035 Verification SHALL cover: credit=10 -> vend, then coin10, GAP, coin10, done; refund=0 throughout.
REQ-036 Verification SHALL cover: credit=4 -> no vend, refund=1, coin10 twice, done.
REQ-037 Verification SHALL cover: credit=6 -> vend at T+1, DONE at T+2, no coins; also credit=0 -> done only.
REQ-038 Verification SHALL cover: credit=9 with ack withheld -> coin10 held exactly 16 cycles, then jam=1 and coin10=0; start -> all outputs 0.
REQ-039 Verification SHALL cover: start asserted mid-PAY, and credit_valid pulsed during PAY -> pulse ignored, reset returns IDLE next cycle with no done.

Source files
------------

// File: rtl/change_dispenser.sv
// Vending change dispenser: accepts a settled credit, vends when the credit covers PRICE,
// then pays the remainder (or a full refund) greedily in 10c/5c coins through a hopper handshake.
module change_dispenser #(
  parameter int PRICE   = 6,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       start,
  input  logic       credit_valid,
  input  logic [3:0] credit,
  input  logic       hopper_ack,
  output logic       vend,
  output logic       coin10,
  output logic       coin5,
  output logic       refund,
  output logic       busy,
  output logic       done,
  output logic       jam,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    VEND = 3'd1,
    PAY  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4,
    JAM  = 3'd5
  } state_t;

  localparam logic [3:0] PRICE_U   = 4'(PRICE);
  localparam logic [7:0] TIMEOUT_U = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] wait_inc;
  logic       refund_q, refund_d;
  logic       vend_q, vend_d;
  logic       coin10_q, coin10_d;
  logic       coin5_q, coin5_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       jam_q, jam_d;

  assign wait_inc = wait_q + 8'd1;

  // Coin handshake: coin10/coin5 is a request held high for the whole PAY stay;
  // the coin counts as ejected on the rising edge where hopper_ack=1 is sampled in PAY.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    wait_d   = wait_q;
    refund_d = refund_q;
    case (state_q)
      IDLE: begin
        if (credit_valid) begin
          if (credit == 4'd0) begin
            state_d  = DONE;
            rem_d    = 4'd0;
            refund_d = 1'b0;
          end else if (credit >= PRICE_U) begin
            state_d  = VEND;
            rem_d    = credit - PRICE_U;
            refund_d = 1'b0;
          end else begin
            state_d  = PAY;
            rem_d    = credit;
            refund_d = 1'b1;
            wait_d   = 8'd0;
          end
        end
      end
      VEND: begin
        wait_d  = 8'd0;
        state_d = (rem_q != 4'd0) ? PAY : DONE;
      end
      PAY: begin
        if (hopper_ack) begin
          rem_d   = (rem_q >= 4'd2) ? rem_q - 4'd2 : rem_q - 4'd1;
          state_d = GAP;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT_U) state_d = JAM;
        end
      end
      GAP: begin
        wait_d  = 8'd0;
        state_d = (rem_q != 4'd0) ? PAY : DONE;
      end
      DONE: state_d = IDLE;
      JAM:  state_d = JAM;
      default: state_d = IDLE;
    endcase
    if (state_d == DONE) refund_d = 1'b0;

    // Outputs are decoded from the next state so they are registered with it.
    vend_d   = (state_d == VEND);
    coin10_d = (state_d == PAY) && (rem_d >= 4'd2);
    coin5_d  = (state_d == PAY) && (rem_d == 4'd1);
    busy_d   = (state_d == VEND) || (state_d == PAY) || (state_d == GAP) || (state_d == JAM);
    done_d   = (state_d == DONE);
    jam_d    = (state_d == JAM);
  end

  always_ff @(posedge clk) begin
    if (start) begin
      state_q  <= IDLE;
      rem_q    <= 4'd0;
      wait_q   <= 8'd0;
      refund_q <= 1'b0;
      vend_q   <= 1'b0;
      coin10_q <= 1'b0;
      coin5_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      jam_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      wait_q   <= wait_d;
      refund_q <= refund_d;
      vend_q   <= vend_d;
      coin10_q <= coin10_d;
      coin5_q  <= coin5_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      jam_q    <= jam_d;
    end
  end

  assign vend      = vend_q;
  assign coin10    = coin10_q;
  assign coin5     = coin5_q;
  assign refund    = refund_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign jam       = jam_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: hand-computed output vectors per cycle plus a
// scoreboard of expected ejected value (5-cent units) per completed transaction.
module tb_change_dispenser;

  logic       clk;
  logic       start;
  logic       credit_valid;
  logic [3:0] credit;
  logic       hopper_ack;
  logic       vend, coin10, coin5, refund, busy, done, jam;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int paid   = 0;
  logic [7:0] exp_q[$];

  change_dispenser #(.PRICE(6), .TIMEOUT(16)) dut (
    .clk          (clk),
    .start        (start),
    .credit_valid (credit_valid),
    .credit       (credit),
    .hopper_ack   (hopper_ack),
    .vend         (vend),
    .coin10       (coin10),
    .coin5        (coin5),
    .refund       (refund),
    .busy         (busy),
    .done         (done),
    .jam          (jam),
    .state_dbg    (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // exp bits: {vend, coin10, coin5, refund, busy, done, jam}
  task automatic check_outs(input string tag, input logic [6:0] exp);
    check(tag, {25'd0, vend, coin10, coin5, refund, busy, done, jam}, {25'd0, exp});
  endtask

  // Advance one clock; account ejected coins and score totals on done.
  task automatic tick();
    int add;
    logic rst_pre;
    add     = 0;
    rst_pre = start;
    if (hopper_ack && coin10) add = 2;
    else if (hopper_ack && coin5) add = 1;
    @(posedge clk);
    #1;
    if (rst_pre) paid = 0;
    else paid += add;
    if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("total_paid", paid, {24'd0, exp_q.pop_front()});
      paid = 0;
    end
  endtask

  task automatic present(input logic [3:0] c);
    credit       = c;
    credit_valid = 1'b1;
    tick();
    credit_valid = 1'b0;
  endtask

  // Hold the current coin request for dly cycles, then acknowledge it; ends in GAP.
  task automatic serve(input string tag, input logic [6:0] pay_exp, input int dly);
    check_outs({tag, "_pay"}, pay_exp);
    for (int i = 0; i < dly; i++) begin
      tick();
      check_outs({tag, "_hold"}, pay_exp);
    end
    hopper_ack = 1'b1;
    tick();
    hopper_ack = 1'b0;
    check_outs({tag, "_gap"}, {3'b000, pay_exp[3], 3'b100});
  endtask

  initial begin
    start        = 1'b1;
    credit_valid = 1'b0;
    credit       = 4'd0;
    hopper_ack   = 1'b0;
    tick();
    tick();
    check_outs("reset_outs", 7'b0000000);
    check("reset_state", {29'd0, state_dbg}, 32'd0);
    start = 1'b0;
    tick();
    check_outs("post_reset_quiet", 7'b0000000);

    // credit 7: vend, one 5c coin acked a cycle after the request
    exp_q.push_back(8'd1);
    present(4'd7);
    check_outs("c7_vend", 7'b1000100);
    tick();
    serve("c7_coin5", 7'b0010100, 1);
    tick();
    check_outs("c7_done", 7'b0000010);
    tick();
    check_outs("c7_idle", 7'b0000000);

    // credit 10: vend then two 10c coins, refund stays low
    exp_q.push_back(8'd4);
    present(4'd10);
    check_outs("c10_vend", 7'b1000100);
    tick();
    serve("c10_coin_a", 7'b0100100, 0);
    tick();
    serve("c10_coin_b", 7'b0100100, 2);
    tick();
    check_outs("c10_done", 7'b0000010);
    tick();

    // credit 4: full refund, two 10c coins, no vend
    exp_q.push_back(8'd4);
    present(4'd4);
    serve("c4_coin_a", 7'b0101100, 0);
    tick();
    serve("c4_coin_b", 7'b0101100, 0);
    tick();
    check_outs("c4_done", 7'b0000010);
    tick();
    check_outs("c4_idle", 7'b0000000);

    // credit 6: exact price; credit_valid during DONE is dropped
    exp_q.push_back(8'd0);
    present(4'd6);
    check_outs("c6_vend", 7'b1000100);
    tick();
    check_outs("c6_done", 7'b0000010);
    present(4'd7);
    check_outs("c6_cv_in_done_ignored", 7'b0000000);

    // credit 0: straight to DONE
    exp_q.push_back(8'd0);
    present(4'd0);
    check_outs("c0_done", 7'b0000010);
    tick();
    check_outs("c0_idle", 7'b0000000);

    // credit 9 with ack withheld: 16 cycles of coin10, then jam until start
    present(4'd9);
    check_outs("c9_vend", 7'b1000100);
    tick();
    check_outs("c9_pay_1", 7'b0100100);
    for (int i = 2; i <= 16; i++) begin
      tick();
      check_outs($sformatf("c9_pay_%0d", i), 7'b0100100);
    end
    tick();
    check_outs("c9_jam", 7'b0000101);
    hopper_ack = 1'b1;
    tick();
    hopper_ack = 1'b0;
    check_outs("c9_jam_sticky", 7'b0000101);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("c9_jam_cleared", 7'b0000000);
    check("c9_state_idle", {29'd0, state_dbg}, 32'd0);

    // credit 10, credit_valid during PAY ignored, then reset mid-PAY
    present(4'd10);
    tick();
    check_outs("mid_pay", 7'b0100100);
    present(4'd3);
    check_outs("mid_pay_cv_ignored", 7'b0100100);
    start      = 1'b1;
    hopper_ack = 1'b1;
    tick();
    start      = 1'b0;
    hopper_ack = 1'b0;
    check_outs("mid_pay_reset", 7'b0000000);
    tick();
    check_outs("mid_pay_no_done", 7'b0000000);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
